// File: rtl/fetch_decode_pipe.sv
// Front-end pipeline registers for the RISC_toy core: PC, F/D and D/E stages,
// hazard-unit stall/flush handling, branch redirect and saturating event counters.
module fetch_decode_pipe #(
  parameter int                PC_W     = 32,
  parameter logic [PC_W-1:0]   RESET_PC = PC_W'(32'h0000_0000),
  parameter int                CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              PCWrite,
  input  logic              FDWrite,
  input  logic              DEFlush,
  input  logic              BrTaken_E,
  input  logic [PC_W-1:0]   BrTarget_E,
  output logic [PC_W-1:0]   IMEM_ADDR,
  input  logic [31:0]       IMEM_DATA,
  input  logic              Load_D,
  input  logic              WEN_D,
  output logic [31:0]       INST_D,
  output logic [PC_W-1:0]   PC_D,
  output logic              Valid_D,
  output logic [4:0]        RA0_D,
  output logic [4:0]        RA1_D,
  output logic [4:0]        WA_D,
  output logic [4:0]        RA0_E,
  output logic [4:0]        RA1_E,
  output logic [4:0]        WA_E,
  output logic              Load_E,
  output logic              WEN_E,
  output logic              Valid_E,
  output logic [PC_W-1:0]   PC_E,
  output logic [CNT_W-1:0]  STALL_CNT,
  output logic [CNT_W-1:0]  BR_CNT
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    sat_inc = (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  // Fetch stage (PC register)
  logic [PC_W-1:0]  pc_p0, pc_p0_nxt;

  // F/D stage
  logic [31:0]      inst_p1, inst_p1_nxt;
  logic [PC_W-1:0]  pc_p1, pc_p1_nxt;
  logic             vld_p1, vld_p1_nxt;

  // D/E stage
  logic [4:0]       ra0_p2, ra0_p2_nxt;
  logic [4:0]       ra1_p2, ra1_p2_nxt;
  logic [4:0]       wa_p2, wa_p2_nxt;
  logic             load_p2, load_p2_nxt;
  logic             wen_p2, wen_p2_nxt;
  logic [PC_W-1:0]  pc_p2, pc_p2_nxt;
  logic             vld_p2, vld_p2_nxt;

  logic [CNT_W-1:0] stall_cnt, stall_cnt_nxt;
  logic [CNT_W-1:0] br_cnt, br_cnt_nxt;

  logic             de_bubble;

  always_comb begin
    pc_p0_nxt     = pc_p0;
    inst_p1_nxt   = inst_p1;
    pc_p1_nxt     = pc_p1;
    vld_p1_nxt    = vld_p1;
    stall_cnt_nxt = stall_cnt;
    br_cnt_nxt    = br_cnt;
    de_bubble     = 1'b0;

    if (BrTaken_E) begin
      // Redirect discards both younger stages; hazard controls are ignored.
      pc_p0_nxt   = BrTarget_E;
      inst_p1_nxt = '0;
      pc_p1_nxt   = '0;
      vld_p1_nxt  = 1'b0;
      de_bubble   = 1'b1;
      br_cnt_nxt  = sat_inc(br_cnt);
    end else begin
      if (PCWrite) begin
        pc_p0_nxt = pc_p0 + PC_W'(4);
      end
      if (FDWrite) begin
        inst_p1_nxt = IMEM_DATA;
        pc_p1_nxt   = pc_p0;
        vld_p1_nxt  = 1'b1;
      end
      if (DEFlush) begin
        de_bubble     = 1'b1;
        stall_cnt_nxt = sat_inc(stall_cnt);
      end else if (!vld_p1) begin
        // An empty F/D slot must never reach E looking like a writer.
        de_bubble = 1'b1;
      end
    end
  end

  always_comb begin
    ra0_p2_nxt  = '0;
    ra1_p2_nxt  = '0;
    wa_p2_nxt   = '0;
    load_p2_nxt = 1'b0;
    wen_p2_nxt  = 1'b1;
    pc_p2_nxt   = '0;
    vld_p2_nxt  = 1'b0;
    if (!de_bubble) begin
      ra0_p2_nxt  = RA0_D;
      ra1_p2_nxt  = RA1_D;
      wa_p2_nxt   = WA_D;
      load_p2_nxt = Load_D;
      wen_p2_nxt  = WEN_D;
      pc_p2_nxt   = pc_p1;
      vld_p2_nxt  = vld_p1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      pc_p0     <= RESET_PC;
      inst_p1   <= '0;
      pc_p1     <= '0;
      vld_p1    <= 1'b0;
      ra0_p2    <= '0;
      ra1_p2    <= '0;
      wa_p2     <= '0;
      load_p2   <= 1'b0;
      wen_p2    <= 1'b1;
      pc_p2     <= '0;
      vld_p2    <= 1'b0;
      stall_cnt <= '0;
      br_cnt    <= '0;
    end else begin
      pc_p0     <= pc_p0_nxt;
      inst_p1   <= inst_p1_nxt;
      pc_p1     <= pc_p1_nxt;
      vld_p1    <= vld_p1_nxt;
      ra0_p2    <= ra0_p2_nxt;
      ra1_p2    <= ra1_p2_nxt;
      wa_p2     <= wa_p2_nxt;
      load_p2   <= load_p2_nxt;
      wen_p2    <= wen_p2_nxt;
      pc_p2     <= pc_p2_nxt;
      vld_p2    <= vld_p2_nxt;
      stall_cnt <= stall_cnt_nxt;
      br_cnt    <= br_cnt_nxt;
    end
  end

  assign IMEM_ADDR = pc_p0;
  assign INST_D    = inst_p1;
  assign PC_D      = pc_p1;
  assign Valid_D   = vld_p1;
  assign RA0_D     = inst_p1[21:17];
  assign RA1_D     = inst_p1[16:12];
  assign WA_D      = inst_p1[26:22];
  assign RA0_E     = ra0_p2;
  assign RA1_E     = ra1_p2;
  assign WA_E      = wa_p2;
  assign Load_E    = load_p2;
  assign WEN_E     = wen_p2;
  assign Valid_E   = vld_p2;
  assign PC_E      = pc_p2;
  assign STALL_CNT = stall_cnt;
  assign BR_CNT    = br_cnt;

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Directed bench for fetch_decode_pipe with a fetch scoreboard queue; a second
// instance with 4-bit counters exercises counter saturation.
module tb_fetch_decode_pipe;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;

  logic        clk = 1'b0;
  logic        rstn, pcwrite, fdwrite, deflush, br_taken;
  logic [31:0] br_target;
  logic [31:0] imem_addr, imem_data, inst_d, pc_d, pc_e;
  logic        load_d, wen_d, valid_d, load_e, wen_e, valid_e;
  logic [4:0]  ra0_d, ra1_d, wa_d, ra0_e, ra1_e, wa_e;
  logic [15:0] stall_cnt, br_cnt;

  logic [31:0] imem_addr4, imem_data4, inst_d4, pc_d4, pc_e4;
  logic        load_d4, wen_d4, valid_d4, load_e4, wen_e4, valid_e4;
  logic [4:0]  ra0_d4, ra1_d4, wa_d4, ra0_e4, ra1_e4, wa_e4;
  logic [3:0]  stall_cnt4, br_cnt4;

  int     total = 0;
  int     bad   = 0;
  fetch_t exp_q[$];
  fetch_t prev;
  logic   have_prev;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    mem_word = (a * 32'h9E37_79B1) ^ 32'h5A3C_C3A5;
  endfunction

  assign imem_data  = mem_word(imem_addr);
  assign imem_data4 = mem_word(imem_addr4);
  assign load_d     = inst_d[31];
  assign wen_d      = inst_d[30];
  assign load_d4    = inst_d4[31];
  assign wen_d4     = inst_d4[30];

  fetch_decode_pipe #(.PC_W(32), .RESET_PC(32'h0), .CNT_W(16)) dut (
    .CLK(clk), .RSTN(rstn), .PCWrite(pcwrite), .FDWrite(fdwrite), .DEFlush(deflush),
    .BrTaken_E(br_taken), .BrTarget_E(br_target), .IMEM_ADDR(imem_addr),
    .IMEM_DATA(imem_data), .Load_D(load_d), .WEN_D(wen_d), .INST_D(inst_d),
    .PC_D(pc_d), .Valid_D(valid_d), .RA0_D(ra0_d), .RA1_D(ra1_d), .WA_D(wa_d),
    .RA0_E(ra0_e), .RA1_E(ra1_e), .WA_E(wa_e), .Load_E(load_e), .WEN_E(wen_e),
    .Valid_E(valid_e), .PC_E(pc_e), .STALL_CNT(stall_cnt), .BR_CNT(br_cnt)
  );

  fetch_decode_pipe #(.PC_W(32), .RESET_PC(32'h0), .CNT_W(4)) dut4 (
    .CLK(clk), .RSTN(rstn), .PCWrite(pcwrite), .FDWrite(fdwrite), .DEFlush(deflush),
    .BrTaken_E(br_taken), .BrTarget_E(br_target), .IMEM_ADDR(imem_addr4),
    .IMEM_DATA(imem_data4), .Load_D(load_d4), .WEN_D(wen_d4), .INST_D(inst_d4),
    .PC_D(pc_d4), .Valid_D(valid_d4), .RA0_D(ra0_d4), .RA1_D(ra1_d4), .WA_D(wa_d4),
    .RA0_E(ra0_e4), .RA1_E(ra1_e4), .WA_E(wa_e4), .Load_E(load_e4), .WEN_E(wen_e4),
    .Valid_E(valid_e4), .PC_E(pc_e4), .STALL_CNT(stall_cnt4), .BR_CNT(br_cnt4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input logic pw, input logic fw, input logic fl, input logic br,
                         input logic [31:0] tgt);
    pcwrite   = pw;
    fdwrite   = fw;
    deflush   = fl;
    br_taken  = br;
    br_target = tgt;
  endtask

  // Straight-line fetch: push each fetched word, pop it when it lands in D,
  // and compare the previously popped word against the E stage.
  task automatic run_straight(input int n);
    fetch_t got;
    for (int i = 0; i < n; i++) begin
      chk("fetch_addr", {32'h0, imem_addr}, {32'h0, exp_pc});
      exp_q.push_back('{pc: exp_pc, inst: mem_word(exp_pc)});
      step();
      exp_pc = exp_pc + 32'd4;
      chk("pc_next", {32'h0, imem_addr}, {32'h0, exp_pc});
      if (exp_q.size() == 0) begin
        chk("queue_empty", 64'd1, 64'd0);
      end else begin
        got = exp_q.pop_front();
        chk("inst_d", {32'h0, inst_d}, {32'h0, got.inst});
        chk("pc_d", {32'h0, pc_d}, {32'h0, got.pc});
        chk("valid_d", {63'h0, valid_d}, 64'd1);
        if (have_prev) begin
          chk("valid_e", {63'h0, valid_e}, 64'd1);
          chk("pc_e", {32'h0, pc_e}, {32'h0, prev.pc});
          chk("ra0_e", {59'h0, ra0_e}, {59'h0, prev.inst[21:17]});
          chk("ra1_e", {59'h0, ra1_e}, {59'h0, prev.inst[16:12]});
          chk("wa_e", {59'h0, wa_e}, {59'h0, prev.inst[26:22]});
          chk("load_e", {63'h0, load_e}, {63'h0, prev.inst[31]});
          chk("wen_e", {63'h0, wen_e}, {63'h0, prev.inst[30]});
        end else begin
          chk("valid_e_first", {63'h0, valid_e}, 64'd0);
        end
        prev      = got;
        have_prev = 1'b1;
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    have_prev = 1'b0;
    exp_pc    = 32'h0;

    // Reset held two cycles
    step();
    step();
    chk("rst_valid_d", {63'h0, valid_d}, 64'd0);
    chk("rst_valid_e", {63'h0, valid_e}, 64'd0);
    chk("rst_wen_e", {63'h0, wen_e}, 64'd1);
    chk("rst_addr", {32'h0, imem_addr}, 64'd0);
    chk("rst_stall", {48'h0, stall_cnt}, 64'd0);
    chk("rst_br", {48'h0, br_cnt}, 64'd0);

    rstn = 1'b1;
    run_straight(4);

    // Load-use stall with IMEM_ADDR at 0x10
    chk("pre_stall_addr", {32'h0, imem_addr}, 64'h10);
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    step();
    chk("stall_addr", {32'h0, imem_addr}, 64'h10);
    chk("stall_inst_d", {32'h0, inst_d}, {32'h0, mem_word(32'hC)});
    chk("stall_valid_e", {63'h0, valid_e}, 64'd0);
    chk("stall_load_e", {63'h0, load_e}, 64'd0);
    chk("stall_wa_e", {59'h0, wa_e}, 64'd0);
    chk("stall_wen_e", {63'h0, wen_e}, 64'd1);
    chk("stall_cnt1", {48'h0, stall_cnt}, 64'd1);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    run_straight(4);

    // Taken branch from 0x20 to 0x40
    chk("pre_br_addr", {32'h0, imem_addr}, 64'h20);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
    step();
    chk("br_addr", {32'h0, imem_addr}, 64'h40);
    chk("br_valid_d", {63'h0, valid_d}, 64'd0);
    chk("br_inst_d", {32'h0, inst_d}, 64'd0);
    chk("br_valid_e", {63'h0, valid_e}, 64'd0);
    chk("br_wen_e", {63'h0, wen_e}, 64'd1);
    chk("br_cnt1", {48'h0, br_cnt}, 64'd1);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    exp_pc    = 32'h40;
    have_prev = 1'b0;
    run_straight(2);

    // Branch together with a load-use stall: branch wins
    set_ctl(1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
    step();
    chk("both_addr", {32'h0, imem_addr}, 64'h80);
    chk("both_stall", {48'h0, stall_cnt}, 64'd1);
    chk("both_br", {48'h0, br_cnt}, 64'd2);
    chk("both_valid_d", {63'h0, valid_d}, 64'd0);
    chk("both_valid_e", {63'h0, valid_e}, 64'd0);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    exp_pc    = 32'h80;
    have_prev = 1'b0;
    run_straight(2);

    // PC wrap at the top of the address space
    set_ctl(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step();
    chk("wrap_tgt", {32'h0, imem_addr}, 64'hFFFF_FFFC);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    exp_pc    = 32'hFFFF_FFFC;
    have_prev = 1'b0;
    run_straight(2);
    chk("wrap_addr", {32'h0, imem_addr}, 64'h4);

    // Counter saturation on the 4-bit instance
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt4", {60'h0, stall_cnt4}, 64'd15);
    chk("sat_cnt16", {48'h0, stall_cnt}, 64'd21);
    step();
    chk("sat_hold4", {60'h0, stall_cnt4}, 64'd15);
    chk("sat_br4", {60'h0, br_cnt4}, 64'd3);

    // Reset arriving during a stall and a branch
    rstn = 1'b0;
    set_ctl(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
    step();
    chk("mrst_addr", {32'h0, imem_addr}, 64'd0);
    chk("mrst_inst_d", {32'h0, inst_d}, 64'd0);
    chk("mrst_pc_d", {32'h0, pc_d}, 64'd0);
    chk("mrst_valid_d", {63'h0, valid_d}, 64'd0);
    chk("mrst_valid_e", {63'h0, valid_e}, 64'd0);
    chk("mrst_wen_e", {63'h0, wen_e}, 64'd1);
    chk("mrst_pc_e", {32'h0, pc_e}, 64'd0);
    chk("mrst_stall", {48'h0, stall_cnt}, 64'd0);
    chk("mrst_br", {48'h0, br_cnt}, 64'd0);
    chk("mrst_stall4", {60'h0, stall_cnt4}, 64'd0);
    rstn = 1'b1;
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    exp_q.delete();
    exp_pc    = 32'h0;
    have_prev = 1'b0;
    run_straight(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
